// File: rtl/awb_gain_calc_if.sv
// AXI4-Stream interface carrying the pixel stream into the AWB engine.
interface axi4_stream_if #(
    parameter int DATA_W = 30
);
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tuser;

    modport master (output tdata, output tvalid, output tuser, input tready);
    modport slave  (input tdata, input tvalid, input tuser, output tready);
endinterface

// File: rtl/awb_gain_calc.sv
// Gray-world auto-white-balance engine.
// - Accumulates per-channel sums of non-saturated pixels over each frame.
// - At every SOF it computes gain_c = sum_ref / sum_c in fixed point using one
//   shared restoring divider.
// - It then publishes all gains on a single edge.
module awb_gain_calc #(
    parameter int                    PX_WIDTH    = 10,
    parameter int                    CH_NUM      = 3,
    parameter int                    REF_CH      = 0,
    parameter int                    FRAME_RES_X = 1920,
    parameter int                    FRAME_RES_Y = 1080,
    parameter int                    FRACT_WIDTH = 10,
    parameter int                    COEF_WIDTH  = PX_WIDTH + FRACT_WIDTH,
    parameter logic [COEF_WIDTH-1:0] GAIN_MAX    = '1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    axi4_stream_if.slave                 video_i,
    input  logic [PX_WIDTH-1:0]          sat_thresh_i,
    output logic [CH_NUM*COEF_WIDTH-1:0] gain_o,
    output logic                         gain_valid_o,
    output logic                         busy_o,
    output logic                         frame_dropped_o
);

    localparam int CNT_W  = $clog2(FRAME_RES_X * FRAME_RES_Y + 1);
    localparam int ACC_W  = PX_WIDTH + CNT_W;
    localparam int ACC_W1 = ACC_W + 1;
    localparam int DIV_W  = ACC_W + FRACT_WIDTH;
    localparam int CH_W   = $clog2(CH_NUM);
    localparam int DCNT_W = $clog2(DIV_W + 1);

    localparam logic [COEF_WIDTH-1:0] FIXED_ONE = COEF_WIDTH'(1) << FRACT_WIDTH;
    localparam logic [CH_W-1:0] FIRST_CH = (REF_CH == 0) ? CH_W'(1) : CH_W'(0);
    localparam logic [CH_W-1:0] LAST_CH  = (REF_CH == CH_NUM - 1) ? CH_W'(CH_NUM - 2)
                                                                   : CH_W'(CH_NUM - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DIV,
        ST_STORE,
        ST_COMMIT
    } state_e;

    state_e                    state_q;
    logic [CH_W-1:0]           ch_q;
    logic [DCNT_W-1:0]         dcnt_q;
    logic [ACC_W-1:0]          rem_q;
    logic [DIV_W-1:0]          quot_q;
    logic [ACC_W-1:0]          sum_q  [CH_NUM];
    logic [ACC_W-1:0]          sum_d  [CH_NUM];
    logic [CNT_W-1:0]          cnt_q;
    logic [CNT_W-1:0]          cnt_d;
    logic [ACC_W-1:0]          snap_q [CH_NUM];
    logic [COEF_WIDTH-1:0]     stage_q[CH_NUM];
    logic [CH_NUM*COEF_WIDTH-1:0] gain_q;
    logic [CH_NUM*COEF_WIDTH-1:0] gain_d;
    logic                      gain_valid_q;
    logic                      busy_q;
    logic                      dropped_q;

    logic [PX_WIDTH-1:0]       px[CH_NUM];
    logic                      px_incl;
    logic                      beat;
    logic                      sof;
    logic [ACC_W-1:0]          divisor;
    logic [ACC_W:0]            rem_shift;
    logic [ACC_W-1:0]          rem_step;
    logic [DIV_W-1:0]          quot_step;
    logic [COEF_WIDTH-1:0]     store_val;
    logic [CH_W-1:0]           ch_next;

    assign video_i.tready = 1'b1;
    assign beat           = video_i.tvalid;
    assign sof            = video_i.tvalid & video_i.tuser;

    // Saturating add of one sample into a channel sum.
    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] acc,
                                                 input logic [PX_WIDTH-1:0] sample);
        logic [ACC_W:0] s;
        s = {1'b0, acc} + ACC_W1'(sample);
        return s[ACC_W] ? '1 : s[ACC_W-1:0];
    endfunction

    // Split the beat into channels; the pixel counts only if no channel exceeds the threshold.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch so no latch is inferred.
        px_incl = 1'b1;
        for (int c = 0; c < CH_NUM; c++) begin
            px[c] = video_i.tdata[c*PX_WIDTH +: PX_WIDTH];
            if (px[c] > sat_thresh_i) px_incl = 1'b0;
        end
    end

    // Next-state of the frame accumulators: restart on SOF, saturate otherwise.
    always_comb begin
        sum_d = sum_q;
        cnt_d = cnt_q;
        if (beat) begin
            if (video_i.tuser) begin
                for (int c = 0; c < CH_NUM; c++) sum_d[c] = px_incl ? ACC_W'(px[c]) : '0;
                cnt_d = px_incl ? CNT_W'(1) : '0;
            end else if (px_incl) begin
                for (int c = 0; c < CH_NUM; c++) sum_d[c] = sat_add(sum_q[c], px[c]);
                cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
            end
        end
    end

    // One restoring-division step plus the clamped result for the current channel.
    always_comb begin
        divisor   = snap_q[ch_q];
        rem_shift = {rem_q, quot_q[DIV_W-1]};
        if (rem_shift >= {1'b0, divisor}) begin
            rem_step  = ACC_W'(rem_shift - {1'b0, divisor});
            quot_step = {quot_q[DIV_W-2:0], 1'b1};
        end else begin
            rem_step  = rem_shift[ACC_W-1:0];
            quot_step = {quot_q[DIV_W-2:0], 1'b0};
        end
        if (divisor == '0 || quot_q > DIV_W'(GAIN_MAX)) store_val = GAIN_MAX;
        else                                            store_val = quot_q[COEF_WIDTH-1:0];
        ch_next = (ch_q + 1'b1 == CH_W'(REF_CH)) ? ch_q + CH_W'(2) : ch_q + 1'b1;
    end

    // Assemble the published gain word; the reference slot is always unity.
    always_comb begin
        gain_d = '0;
        for (int c = 0; c < CH_NUM; c++)
            gain_d[c*COEF_WIDTH +: COEF_WIDTH] = (c == REF_CH) ? FIXED_ONE : stage_q[c];
    end

    // Frame accumulators.
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: sequential state is assigned with <= so every register sees pre-edge values.
        if (rst_i) begin
            sum_q <= '{default: '0};
            cnt_q <= '0;
        end else begin
            sum_q <= sum_d;
            cnt_q <= cnt_d;
        end
    end

    // Snapshot/drop handling and the gain FSM with its serial divider.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            ch_q         <= FIRST_CH;
            dcnt_q       <= '0;
            rem_q        <= '0;
            quot_q       <= '0;
            snap_q       <= '{default: '0};
            gain_q       <= {CH_NUM{FIXED_ONE}};
            gain_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            dropped_q    <= 1'b0;
        end else begin
            gain_valid_q <= 1'b0;
            dropped_q    <= 1'b0;
            busy_q       <= (state_q != ST_IDLE) && (state_q != ST_COMMIT);
            if (sof) begin
                if (state_q == ST_IDLE) snap_q    <= sum_q;
                else                    dropped_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    // The pixel count is consumed here, at the snapshot edge.
                    if (sof && cnt_q != '0) begin
                        state_q <= ST_LOAD;
                        ch_q    <= FIRST_CH;
                    end
                end
                ST_LOAD: begin
                    quot_q  <= {snap_q[REF_CH], {FRACT_WIDTH{1'b0}}};
                    rem_q   <= '0;
                    dcnt_q  <= DCNT_W'(DIV_W);
                    state_q <= ST_DIV;
                end
                ST_DIV: begin
                    rem_q  <= rem_step;
                    quot_q <= quot_step;
                    dcnt_q <= dcnt_q - 1'b1;
                    if (dcnt_q == DCNT_W'(1)) state_q <= ST_STORE;
                end
                ST_STORE: begin
                    if (ch_q == LAST_CH) begin
                        state_q <= ST_COMMIT;
                    end else begin
                        ch_q    <= ch_next;
                        state_q <= ST_LOAD;
                    end
                end
                ST_COMMIT: begin
                    gain_q       <= gain_d;
                    gain_valid_q <= 1'b1;
                    state_q      <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Per-channel staging of divider results until the atomic commit.
    always_ff @(posedge clk_i) begin
        // NOTE: staging words need no reset; every slot read at commit was written earlier in the same computation.
        if (state_q == ST_STORE) stage_q[ch_q] <= store_val;
    end

    assign gain_o          = gain_q;
    assign gain_valid_o    = gain_valid_q;
    assign busy_o          = busy_q;
    assign frame_dropped_o = dropped_q;

endmodule

// File: doc/awb_gain_calc.md
# awb_gain_calc

Next-generation gray-world auto-white-balance statistics and gain engine for a video stream with `CH_NUM` colour channels. It accumulates per-channel sums over each frame and excludes saturated pixels. At every start-of-frame it computes fixed-point gains `gain_c = sum_ref / sum_c` for every channel relative to a selectable reference channel, using one shared serial divider. It then publishes all gains atomically to the downstream white-balance multiplier.

## Interface
- `PX_WIDTH`, 10: bits per channel sample.
- `CH_NUM`, 3: number of channels; must be at least 2.
- `REF_CH`, 0: index of the reference channel; its gain is always `FIXED_ONE`.
- `FRAME_RES_X`, 1920: frame width in pixels.
- `FRAME_RES_Y`, 1080: frame height in pixels.
- `FRACT_WIDTH`, 10: fractional bits of each gain.
- `COEF_WIDTH`, `PX_WIDTH+FRACT_WIDTH`: gain word width.
- `GAIN_MAX`, all-ones of `COEF_WIDTH`: clamp value for gains.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `video_i`  `axi4_stream_if.slave`  pixel stream.
  - tdata is `CH_NUM*PX_WIDTH` bits; channel c occupies `[c*PX_WIDTH +: PX_WIDTH]`.
  - tuser marks the first pixel of a frame (SOF).
- `sat_thresh_i`  in  `PX_WIDTH`  a pixel is included only if every channel is `<= sat_thresh_i`.
- `gain_o`  out  `CH_NUM*COEF_WIDTH`  gain for channel c at `[c*COEF_WIDTH +: COEF_WIDTH]`, unsigned `PX_WIDTH.FRACT_WIDTH`.
- `gain_valid_o`  out  1  one-cycle pulse; `gain_o` was updated on this edge.
- `busy_o`  out  1  gain computation in progress.
- `frame_dropped_o`  out  1  one-cycle pulse; the statistics of a finished frame were discarded.

## Operation
- `video_i.tready` is tied to 1. A beat counts when tvalid is high.
- Derived widths:
  - `CNT_W = $clog2(FRAME_RES_X*FRAME_RES_Y+1)`
  - `ACC_W = PX_WIDTH+CNT_W`
  - `DIV_W = ACC_W+FRACT_WIDTH`
  - `FIXED_ONE = 1 << FRACT_WIDTH`
- Accumulation:
  - Each included beat adds every channel to its `ACC_W` sum and increments the pixel count.
  - Sums and count saturate at all-ones; they do not wrap.
  - Excluded beats change nothing.
- SOF beat:
  - If the FSM is IDLE, copy sums and count into snapshot registers.
  - If the FSM is busy, discard them and pulse `frame_dropped_o`.
  - In either case the accumulators restart from the SOF pixel: its value if included, else 0.
- FSM states:
  - IDLE: waits for a snapshot. On snapshot with count 0 (first frame after reset, or all pixels excluded), stay in IDLE; no update, no pulse. On snapshot with count > 0, go to LOAD with the lowest non-reference channel.
  - LOAD: the divider loads dividend `sum_ref << FRACT_WIDTH` (`DIV_W` bits) and divisor `sum_c`. Next state is DIV.
  - DIV: restoring division, one quotient bit per cycle, `DIV_W` cycles. Next state is STORE.
  - STORE: write the staging register for channel c with one of:
    - `GAIN_MAX` if `sum_c == 0`;
    - `GAIN_MAX` if the quotient exceeds `GAIN_MAX`;
    - otherwise the quotient truncated to `COEF_WIDTH`.
  - After STORE, go to LOAD for the next non-reference channel, or to COMMIT if none remain.
  - COMMIT: copy all staging registers into `gain_o`, with the `REF_CH` slot forced to `FIXED_ONE`. Pulse `gain_valid_o`. Next state is IDLE.
- `busy_o` is 1 in every state except IDLE.
- `sat_thresh_i` is sampled per beat. All-ones includes every pixel.
- The pixel count is used only for the zero check; means are never computed because the counts cancel in the ratio.

## Timing
- Reset values:
  - every `gain_o` slot = `FIXED_ONE`;
  - `gain_valid_o` = 0;
  - `busy_o` = 0;
  - `frame_dropped_o` = 0;
  - sums, count and snapshot = 0;
  - FSM in IDLE.
- Reset mid-computation aborts the computation; `gain_o` returns to `FIXED_ONE`.
- Latency: for a valid SOF accepted at edge T, `gain_o` updates and `gain_valid_o` is high at edge `T + 1 + (CH_NUM-1)*(DIV_W+2)`.
- `busy_o` rises at T+1 and falls at the COMMIT edge.
- `gain_o` is stable between commits; all channels change on the same edge.
- A frame must be longer than the latency above for every frame to be used. Otherwise frames are dropped with a pulse and no corruption occurs.
- `frame_dropped_o` is high on the edge after the dropped SOF.

## Test plan
All scenarios use `PX_WIDTH=10`, `CH_NUM=3`, `REF_CH=0`, `FRACT_WIDTH=10`, and a 4x2 frame.
1. Reset, then idle -> `gain_o = {0x400,0x400,0x400}`; `gain_valid_o`, `busy_o` and `frame_dropped_o` all 0.
2. Frame of (ch0=200, ch1=100, ch2=400), `sat_thresh_i=0x3FF`, then SOF -> after the exact latency, ch0=0x400, ch1=0x800, ch2=0x200, with a single `gain_valid_o` pulse.
3. `sat_thresh_i=1000`; 4 pixels (200,100,400) and 4 pixels (200,100,1023) -> same gains as scenario 2, since the saturated pixels are excluded.
4. ch1=0 on all pixels -> ch1 gain = 0xFFFFF (`GAIN_MAX`). Separately, ch1=1 with ch0=1023 -> 1023.0 = 0xFFC00, not clamped.
5. All pixels excluded (`sat_thresh_i=0`, nonzero data) -> no `gain_valid_o`, gains unchanged, `busy_o` stays 0.
6. Two SOFs 3 beats apart -> second frame dropped, `frame_dropped_o` pulses once, gains reflect only the first frame. Asserting `rst_i` while `busy_o=1` -> gains return to 0x400 with no pulse.
